// File: rtl/core_seq_pkg.sv
// Shared constants for the RV32I multi-cycle sequencer: FSM state encoding,
// base opcodes, the canonical NOP and a legal-opcode check.
package core_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
            OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP,
            OPCODE_MISC_MEM, OPCODE_SYSTEM: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// Sequencer boundary: imem/dmem handshakes, decode/control hand-off and status.
// CORE_SEQ_PERF_EN adds the stall_cnt_o performance counter.
interface core_seq_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic [DWIDTH-1:0] insn_o;
    logic [AWIDTH-1:0] pc_o;
    logic [6:0]        opcode_i;
    logic              regwren_i;
    logic              memren_i;
    logic              memwren_i;
    logic              pcsel_i;
    logic [AWIDTH-1:0] target_i;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic              dmem_ack_i;
    logic              dec_en_o;
    logic              ex_en_o;
    logic              rf_we_o;
    logic              retire_o;
    logic [31:0]       instret_o;
    logic              halt_o;
    logic              trap_o;
    logic [2:0]        state_o;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0]       stall_cnt_o;
`endif

    modport master (
`ifdef CORE_SEQ_PERF_EN
        output stall_cnt_o,
`endif
        output imem_req_o, imem_addr_o, insn_o, pc_o, dmem_req_o, dmem_we_o,
               dec_en_o, ex_en_o, rf_we_o, retire_o, instret_o, halt_o,
               trap_o, state_o,
        input  imem_ack_i, imem_rdata_i, opcode_i, regwren_i, memren_i,
               memwren_i, pcsel_i, target_i, dmem_ack_i
    );

    modport slave (
`ifdef CORE_SEQ_PERF_EN
        input  stall_cnt_o,
`endif
        input  imem_req_o, imem_addr_o, insn_o, pc_o, dmem_req_o, dmem_we_o,
               dec_en_o, ex_en_o, rf_we_o, retire_o, instret_o, halt_o,
               trap_o, state_o,
        output imem_ack_i, imem_rdata_i, opcode_i, regwren_i, memren_i,
               memwren_i, pcsel_i, target_i, dmem_ack_i
    );

endinterface

// File: rtl/core_seq_timeout.sv
// Memory-ack wait counter shared by FETCH and MEM; expired is high on the
// LIMIT-th consecutive waiting cycle.
module core_seq_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/core_seq.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB ordering, PC, memory
// handshakes and retire accounting. CORE_SEQ_PERF_EN adds stall_cnt_o.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int              AWIDTH      = 32,
    parameter int              DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] RESET_PC  = 32'h0100_0000,
    parameter int              ACK_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    core_seq_if.master bus
);
    state_t            state;
    logic              fetch_req;
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [31:0]       instret;
    logic              dmem_req, dmem_we, dec_en, ex_en, rf_we, retire, halt, trap;

    logic              waiting, ack_now, expired, misaligned;
    logic [AWIDTH-1:0] next_pc;

    assign waiting    = (state == FETCH) || (state == MEM);
    assign ack_now    = (state == FETCH) ? bus.imem_ack_i : bus.dmem_ack_i;
    assign misaligned = bus.pcsel_i && bus.target_i[1];
    assign next_pc    = bus.pcsel_i ? (bus.target_i & ~AWIDTH'(1)) : pc + AWIDTH'(4);

    core_seq_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .count  (waiting && !ack_now),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
            pc        <= RESET_PC;
            insn      <= DWIDTH'(INSN_NOP);
            instret   <= '0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dec_en    <= 1'b0;
            ex_en     <= 1'b0;
            rf_we     <= 1'b0;
            retire    <= 1'b0;
            halt      <= 1'b0;
            trap      <= 1'b0;
        end else begin
            dec_en <= 1'b0;
            ex_en  <= 1'b0;
            rf_we  <= 1'b0;
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.imem_ack_i) begin
                        insn      <= bus.imem_rdata_i;
                        fetch_req <= 1'b0;
                        dec_en    <= 1'b1;
                        state     <= DECODE;
                    end else if (expired) begin
                        fetch_req <= 1'b0;
                        trap      <= 1'b1;
                        state     <= TRAP;
                    end
                end
                DECODE: begin
                    ex_en <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!is_legal_opcode(bus.opcode_i)) begin
                        trap  <= 1'b1;
                        state <= TRAP;
                    end else if (bus.opcode_i == OPCODE_SYSTEM) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end else if (bus.memren_i || bus.memwren_i) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= bus.memwren_i;
                        state    <= MEM;
                    end else begin
                        // Strobes suppressed up front when WB will fault
                        rf_we  <= bus.regwren_i && !misaligned;
                        retire <= !misaligned;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack_i) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        rf_we    <= bus.regwren_i && !misaligned;
                        retire   <= !misaligned;
                        state    <= WB;
                    end else if (expired) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        trap     <= 1'b1;
                        state    <= TRAP;
                    end
                end
                WB: begin
                    if (misaligned) begin
                        trap  <= 1'b1;
                        state <= TRAP;
                    end else begin
                        pc        <= next_pc;
                        instret   <= instret + 32'd1;
                        fetch_req <= 1'b1;
                        state     <= FETCH;
                    end
                end
                HALT, TRAP: ;
                default: begin
                    trap  <= 1'b1;
                    state <= TRAP;
                end
            endcase
        end
    end

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (((state == FETCH && bus.imem_req_o) || (state == MEM && dmem_req))
                     && !ack_now && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`endif

    // NOTE: the fetch request flop resets to 1 so fetch starts the cycle reset
    // releases; gating with rst keeps it low, and drops it at once, under reset.
    assign bus.imem_req_o  = fetch_req && rst;
    assign bus.imem_addr_o = pc;
    assign bus.pc_o        = pc;
    assign bus.insn_o      = insn;
    assign bus.instret_o   = instret;
    assign bus.dmem_req_o  = dmem_req;
    assign bus.dmem_we_o   = dmem_we;
    assign bus.dec_en_o    = dec_en;
    assign bus.ex_en_o     = ex_en;
    assign bus.rf_we_o     = rf_we;
    assign bus.retire_o    = retire;
    assign bus.halt_o      = halt;
    assign bus.trap_o      = trap;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq: reset, ALU/load/store/jump flow,
// illegal opcode, fetch timeout, misaligned target and halt/reset restart.
module tb_core_seq;
    import core_seq_pkg::*;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    core_seq_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    core_seq #(
        .AWIDTH(32), .DWIDTH(32), .RESET_PC(RPC), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    // Presents an instruction with a zero-wait fetch ack and its control word
    task automatic set_insn(input logic [31:0] word, input logic [6:0] op,
                            input logic rw, input logic mr, input logic mw,
                            input logic ps, input logic [31:0] tgt);
        bus.imem_rdata_i = word;
        bus.imem_ack_i   = 1'b1;
        bus.opcode_i     = op;
        bus.regwren_i    = rw;
        bus.memren_i     = mr;
        bus.memwren_i    = mw;
        bus.pcsel_i      = ps;
        bus.target_i     = tgt;
    endtask

    initial begin
        bus.imem_ack_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        set_insn(32'h0, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.imem_ack_i = 1'b0;
        repeat (2) tick();

        // Reset values, sampled while rst is low
        check("rst_state", bus.state_o, 32'(FETCH));
        check("rst_pc", bus.pc_o, RPC);
        check("rst_insn", bus.insn_o, 32'h0000_0013);
        check("rst_instret", bus.instret_o, 32'd0);
        check("rst_flags", {bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.dec_en_o,
                            bus.ex_en_o, bus.rf_we_o, bus.retire_o, bus.halt_o, bus.trap_o},
              32'd0);

        // ADDI with zero-wait imem: retire in cycle 4
        set_insn(32'h0010_0093, OPCODE_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        release_reset();
        check("addi_req", bus.imem_req_o, 32'd1);
        check("addi_addr", bus.imem_addr_o, RPC);
        tick(); bus.imem_ack_i = 1'b0;
        check("addi_dec_state", bus.state_o, 32'(DECODE));
        check("addi_dec_en", bus.dec_en_o, 32'd1);
        check("addi_insn", bus.insn_o, 32'h0010_0093);
        tick();
        check("addi_ex_en", {bus.ex_en_o, bus.dec_en_o}, 32'b10);
        tick();
        check("addi_wb", {bus.retire_o, bus.rf_we_o}, 32'b11);
        tick();
        check("addi_fetch", bus.state_o, 32'(FETCH));
        check("addi_pc", bus.pc_o, 32'h0100_0004);
        check("addi_instret", bus.instret_o, 32'd1);
        check("addi_retire_pulse", bus.retire_o, 32'd0);

        // LW with dmem ack three cycles late: req held 4 cycles, 8 total
        set_insn(32'h0000_2103, OPCODE_LOAD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(); bus.imem_ack_i = 1'b0;
        tick();
        tick();
        check("lw_mem_state", bus.state_o, 32'(MEM));
        check("lw_req_c4", {bus.dmem_req_o, bus.dmem_we_o}, 32'b10);
        tick();
        check("lw_req_c5", bus.dmem_req_o, 32'd1);
        tick();
        check("lw_req_c6", bus.dmem_req_o, 32'd1);
        tick();
        check("lw_req_c7", bus.dmem_req_o, 32'd1);
        bus.dmem_ack_i = 1'b1;
        tick(); bus.dmem_ack_i = 1'b0;
        check("lw_wb_state", bus.state_o, 32'(WB));
        check("lw_wb", {bus.dmem_req_o, bus.rf_we_o, bus.retire_o}, 32'b011);
        tick();
        check("lw_pc", bus.pc_o, 32'h0100_0008);
        check("lw_instret", bus.instret_o, 32'd2);

        // SW, dmem ack raised early must be ignored until req is up
        set_insn(32'h0020_2223, OPCODE_STORE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(); bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b1;
        tick();
        check("sw_exec_no_req", {bus.state_o, bus.dmem_req_o}, {29'd0, EXEC, 1'b0});
        tick();
        check("sw_mem", {bus.dmem_req_o, bus.dmem_we_o}, 32'b11);
        tick(); bus.dmem_ack_i = 1'b0;
        check("sw_wb", {bus.rf_we_o, bus.retire_o}, 32'b01);
        tick();
        check("sw_pc", bus.pc_o, 32'h0100_000C);
        check("sw_instret", bus.instret_o, 32'd3);

        // JAL with odd target: bit 0 cleared
        set_insn(32'h0f40_00ef, OPCODE_JAL, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0100_0101);
        tick(); bus.imem_ack_i = 1'b0;
        tick();
        tick();
        check("jal_wb", {bus.rf_we_o, bus.retire_o}, 32'b11);
        tick();
        check("jal_pc", bus.pc_o, 32'h0100_0100);
        check("jal_addr", bus.imem_addr_o, 32'h0100_0100);
        check("jal_instret", bus.instret_o, 32'd4);

        // Illegal opcode: trap after EXEC, fetch stops, acks ignored
        set_insn(32'hffff_ffff, 7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        check("ill_trap", {bus.state_o, bus.trap_o}, {29'd0, TRAP, 1'b1});
        repeat (3) tick();
        check("ill_no_req", bus.imem_req_o, 32'd0);
        check("ill_instret", bus.instret_o, 32'd4);
        check("ill_pc", bus.pc_o, 32'h0100_0100);
        check("ill_sticky", bus.trap_o, 32'd1);

        // imem never acks: trap on the 16th waiting cycle
        start_reset();
        check("to_rst_trap", bus.trap_o, 32'd0);
        bus.imem_ack_i = 1'b0;
        release_reset();
        repeat (15) tick();
        check("to_wait", {bus.state_o, bus.imem_req_o}, {29'd0, FETCH, 1'b1});
        tick();
        check("to_trap", {bus.state_o, bus.trap_o}, {29'd0, TRAP, 1'b1});
        check("to_pc", bus.pc_o, RPC);
`ifdef CORE_SEQ_PERF_EN
        check("to_stall_cnt", bus.stall_cnt_o, 32'd16);
        tick();
        check("to_stall_hold", bus.stall_cnt_o, 32'd16);
`endif

        // JALR to a target with bit 1 set: no retire, no write, trap
        start_reset();
        set_insn(32'h0060_0067, OPCODE_JALR, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0100_0006);
        release_reset();
        tick(); bus.imem_ack_i = 1'b0;
        tick();
        tick();
        check("mis_wb", {bus.state_o, bus.retire_o, bus.rf_we_o}, {28'd0, WB, 2'b00});
        tick();
        check("mis_trap", bus.trap_o, 32'd1);
        check("mis_pc", bus.pc_o, RPC);
        check("mis_instret", bus.instret_o, 32'd0);

        // ECALL halts; reset mid-HALT restores everything and refetches
        start_reset();
        set_insn(32'h0000_0073, OPCODE_SYSTEM, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        release_reset();
        tick(); bus.imem_ack_i = 1'b0;
        tick();
        tick();
        check("ecall_halt", {bus.state_o, bus.halt_o}, {29'd0, HALT, 1'b1});
        tick();
        check("ecall_halt_hold", {bus.halt_o, bus.imem_req_o, bus.instret_o[0]}, 32'b100);
        start_reset();
        check("halt_rst_state", bus.state_o, 32'(FETCH));
        check("halt_rst_flags", {bus.halt_o, bus.trap_o, bus.imem_req_o}, 32'd0);
        check("halt_rst_pc", bus.pc_o, RPC);
        check("halt_rst_insn", bus.insn_o, 32'h0000_0013);
        set_insn(32'h0010_0093, OPCODE_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        release_reset();
        check("restart_req", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, RPC});
        tick(); bus.imem_ack_i = 1'b0;
        check("restart_insn", bus.insn_o, 32'h0010_0093);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I core. It drives the fetch/decode/execute/memory/writeback order around the decode and control units.
- Owns the PC, the imem/dmem request handshakes, stage enables, register-file write strobe and retire accounting.
- Sits between instruction memory, decode, control and data memory. It is the single point deciding when each stage may act.

Parameters:
- AWIDTH, 32, address/PC width
- DWIDTH, 32, instruction/data width
- RESET_PC, 32'h0100_0000, PC value loaded at reset
- ACK_TIMEOUT, 16, max cycles a memory request may wait for ack before trapping

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  AWIDTH  fetch address (= pc_o)
- imem_ack_i  in  1  fetch data valid
- imem_rdata_i  in  DWIDTH  fetched instruction
- insn_o  out  DWIDTH  instruction presented to decode
- pc_o  out  AWIDTH  current PC
- opcode_i  in  7  decoded opcode
- regwren_i, memren_i, memwren_i, pcsel_i  in  1 each  control-unit outputs
- target_i  in  AWIDTH  branch/jump target from ALU
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data request is a store
- dmem_ack_i  in  1  data access complete
- dec_en_o, ex_en_o  out  1 each  single-cycle stage enables
- rf_we_o  out  1  register-file write strobe
- retire_o  out  1  one-cycle pulse per completed instruction
- instret_o  out  32  retired-instruction count
- halt_o  out  1  sticky, ECALL/EBREAK reached
- trap_o  out  1  sticky error
- state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, pc_o=RESET_PC, insn_o=INSN_NOP, instret_o=0.
  - All req/en/we/pulse/sticky outputs are 0.
- States and transitions:
  - FETCH: imem_req_o=1. Stay until imem_ack_i=1, then latch imem_rdata_i into insn_o and go to DECODE.
  - DECODE: dec_en_o=1 for 1 cycle; decode output is registered. Go to EXEC.
  - EXEC: ex_en_o=1.
    - Opcode outside the RV32I set {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM}: go to TRAP.
    - SYSTEM: go to HALT.
    - memren_i|memwren_i: go to MEM.
    - Otherwise: go to WB.
  - MEM: dmem_req_o=1, dmem_we_o=memwren_i. Stay until dmem_ack_i=1, then go to WB.
  - WB:
    - rf_we_o=regwren_i and retire_o=1 for exactly 1 cycle; instret_o++ (wraps at 2^32).
    - PC update: pc_o <= pcsel_i ? {target_i[AWIDTH-1:1],1'b0} : pc_o+4 (mod 2^AWIDTH).
    - If the masked target has bit1=1: go to TRAP, with no PC update, no retire and no rf write.
    - Otherwise go to FETCH.
  - HALT: halt_o=1. Terminal until reset; no requests issued.
  - TRAP: trap_o=1. Terminal until reset; pc_o holds the faulting PC.
- Handshake rules:
  - A req stays high and its address/we stay stable until the ack is sampled.
  - An ack in the same cycle the req rises is legal; a zero-wait memory gives 1 cycle per memory state.
  - An ack while the matching req is low is ignored.
- Timeout: a wait counter resets on state entry. If ack is still absent after ACK_TIMEOUT cycles in FETCH or MEM, go to TRAP.
- Latency: minimum 4 cycles per non-memory instruction and 5 per load/store.
- Reset asserted mid-operation aborts any request at once; the bench may see a partial request dropped.

Optional Feature:
- CORE_SEQ_PERF_EN defined:
  - Adds stall_cnt_o (32 bits), counting cycles spent in FETCH or MEM with req=1 and ack=0.
  - The counter saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Existing constants package: state enum typedef (FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP); OPCODE_* values; INSN_NOP; a legal-opcode check function.
- One sub-module, core_seq_timeout: loadable wait counter with an expired flag, instanced once and shared by FETCH and MEM.

Test Plan:
- Reset release with zero-wait imem, ADDI fetched → imem_addr_o=0x01000000; retire_o at cycle 4; pc_o=0x01000004; instret_o=1.
- LW with dmem ack delayed 3 cycles → dmem_req_o held 4 cycles, dmem_we_o=0, rf_we_o=1 in WB; total 8 cycles.
- SW followed by JAL with target_i=0x01000101 → rf_we_o=0 for SW, dmem_we_o=1; after JAL, pc_o=0x01000100.
- Opcode 7'b1111111 → trap_o=1 after EXEC; no further imem_req_o; instret_o unchanged.
- imem_ack_i never asserted → trap_o=1 after ACK_TIMEOUT=16 wait cycles. With CORE_SEQ_PERF_EN, stall_cnt_o=16.
- ECALL, then rst pulsed low mid-HALT → halt_o=1, then all outputs return to reset values; fetch restarts at 0x01000000.
